// File: rtl/twobyonemux_seq_checker_if.sv
// twobyonemux_seq_checker_if: stimulus/response bundle between the sequence checker and the mux cell
interface twobyonemux_seq_checker_if #(parameter int ERR_W = 8);
    logic             start;
    logic             s;
    logic             a;
    logic             b;
    logic             y;
    logic             busy;
    logic             done;
    logic             pass;
    logic [ERR_W-1:0] err_cnt;
    logic [7:0]       fail_vec;
    modport master (input start, y, output s, a, b, busy, done, pass, err_cnt, fail_vec);
    modport slave (output start, y, input s, a, b, busy, done, pass, err_cnt, fail_vec);
endinterface

// File: rtl/twobyonemux_seq_checker.sv
// twobyonemux_seq_checker: sweeps all s/a/b vectors into a 2:1 mux and checks y = s ? b : a
// Optional TWOBYONEMUX_SYNC_EN inserts a 2-flop synchronizer on y and lengthens each hold by 2 cycles.
module twobyonemux_seq_checker #(
    parameter int SETTLE = 2,
    parameter int PASSES = 1,
    parameter int ERR_W  = 8
) (
    input logic clk,
    input logic rst_n,
    twobyonemux_seq_checker_if.master bus
);
`ifdef TWOBYONEMUX_SYNC_EN
    localparam int HOLD = SETTLE + 2;
`else
    localparam int HOLD = SETTLE;
`endif
    localparam int CW = $clog2(HOLD + 1);
    localparam int PW = PASSES > 1 ? $clog2(PASSES) : 1;

    typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_SAMPLE, S_DONE} state_t;

    state_t           state;
    logic [2:0]       idx;
    logic [CW-1:0]    cnt;
    logic [PW-1:0]    pcnt;
    logic [ERR_W-1:0] err_cnt;
    logic [7:0]       fail_vec;
    logic             busy;
    logic             done;
    logic             pass;
    logic             yc;
    logic             miss;
    logic             last;
    logic [ERR_W-1:0] err_nxt;
    logic [7:0]       fail_nxt;

`ifdef TWOBYONEMUX_SYNC_EN
    logic [1:0] sync;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) sync <= 2'b00;
        else sync <= {sync[0], bus.y};
    assign yc = sync[1];
`else
    assign yc = bus.y;
`endif

    assign miss     = yc != (idx[2] ? idx[0] : idx[1]);
    assign last     = idx == 3'd7 && pcnt == PW'(PASSES - 1);
    assign err_nxt  = (miss && err_cnt != '1) ? err_cnt + ERR_W'(1) : err_cnt;
    assign fail_nxt = fail_vec | (miss ? 8'b1 << idx : 8'h00);

    assign {bus.s, bus.a, bus.b} = idx;
    assign bus.busy     = busy;
    assign bus.done     = done;
    assign bus.pass     = pass;
    assign bus.err_cnt  = err_cnt;
    assign bus.fail_vec = fail_vec;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            idx      <= 3'd0;
            cnt      <= '0;
            pcnt     <= '0;
            err_cnt  <= '0;
            fail_vec <= 8'h00;
            busy     <= 1'b0;
            done     <= 1'b0;
            pass     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (bus.start) begin
                    state    <= S_SETTLE;
                    idx      <= 3'd0;
                    cnt      <= '0;
                    pcnt     <= '0;
                    err_cnt  <= '0;
                    fail_vec <= 8'h00;
                    pass     <= 1'b0;
                    busy     <= 1'b1;
                end
                S_SETTLE: begin
                    cnt <= cnt + CW'(1);
                    if (cnt == CW'(HOLD - 1)) state <= S_SAMPLE;
                end
                S_SAMPLE: begin
                    err_cnt  <= err_nxt;
                    fail_vec <= fail_nxt;
                    cnt      <= '0;
                    if (last) begin
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= err_nxt == '0;
                    end else begin
                        state <= S_SETTLE;
                        idx   <= idx + 3'd1;
                        if (idx == 3'd7) pcnt <= pcnt + PW'(1);
                    end
                end
                default: begin
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end
endmodule
